// File: rtl/display_scan_mux_pkg.sv
// Shared types and defaults for the multiplexed 7-segment scanner.
// Holds the FSM encoding, digit-enable polarity and default timing.
package display_scan_mux_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_DEAD = 2'd1,
      ST_ON   = 2'd2
   } scan_state_e;

   // Level that lights a digit on DIG_N (common cathode, active-low).
   localparam logic DIG_ACTIVE = 1'b0;

   localparam int DEF_SCAN_DIV = 50000;
   localparam int DEF_DEAD_CYC = 16;

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer for the display scanner: mod-SCAN_DIV counter with sync clear.
// Flags the last dead-time cycle and the last cycle of each slot.
module scan_prescaler #(
   parameter int SCAN_DIV = 50000,
   parameter int DEAD_CYC = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic dead_end,
   output logic slot_end
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign dead_end = (cnt_q == CW'(DEAD_CYC - 1));
   assign slot_end = (cnt_q == CW'(SCAN_DIV - 1));

   // Next count: wrap at end of slot, hold at zero while cleared.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || slot_end) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed scanner for a common-cathode 7-segment display.
// Optional LEADING_ZERO_BLANK_EN keeps digits above the top nonzero nibble dark.
module display_scan_mux
   import display_scan_mux_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = DEF_SCAN_DIV,
   parameter int DEAD_CYC = DEF_DEAD_CYC
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   D,
   output logic [3:0]            A,
   output logic [DIGITS-1:0]     DIG_N,
   output logic                  frame_start
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DW = 4 * DIGITS;

   scan_state_e       state_q;
   scan_state_e       state_d;
   logic [IW-1:0]     idx_q;
   logic [IW-1:0]     idx_d;
   logic [DW-1:0]     snap_q;
   logic [DW-1:0]     snap_d;
   logic [3:0]        a_q;
   logic [3:0]        a_d;
   logic [DIGITS-1:0] dig_q;
   logic [DIGITS-1:0] dig_d;
   logic              fs_q;
   logic              fs_d;
   logic              clr;
   logic              dead_end;
   logic              slot_end;
   logic              step;
   logic              wrap;
   logic              load;
   logic              show;

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] lit_q;
   logic [DIGITS-1:0] lit_d;

   // A digit is lit if it or any higher nibble is nonzero; digit 0 always.
   function automatic logic [DIGITS-1:0] lit_mask(input logic [DW-1:0] v);
      logic [DIGITS-1:0] m;
      logic              seen;
      m    = '0;
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen = seen | (v[4*i +: 4] != 4'h0);
         m[i] = seen | (i == 0);
      end
      return m;
   endfunction
`endif

   // Counter restarts whenever the scan is idle or being shut off.
   assign clr = (state_q == ST_OFF) || !en;

   scan_prescaler #(
      .SCAN_DIV (SCAN_DIV),
      .DEAD_CYC (DEAD_CYC)
   ) u_presc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .dead_end (dead_end),
      .slot_end (slot_end)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: dead time, then lit, slot after slot; en=0 goes dark.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OFF: begin
            if (en) state_d = ST_DEAD;
         end
         ST_DEAD: begin
            if (!en)          state_d = ST_OFF;
            else if (dead_end) state_d = ST_ON;
         end
         ST_ON: begin
            if (!en)          state_d = ST_OFF;
            else if (slot_end) state_d = ST_DEAD;
         end
         default: state_d = ST_OFF;
      endcase
   end

   // Digit index and frame snapshot; a new frame begins on start or wrap.
   always_comb begin
      wrap   = (idx_q == IW'(DIGITS - 1));
      step   = en && (state_q == ST_ON) && slot_end;
      load   = (en && (state_q == ST_OFF)) || (step && wrap);
      idx_d  = idx_q;
      if (clr) begin
         idx_d = '0;
      end else if (step) begin
         idx_d = wrap ? '0 : idx_q + IW'(1);
      end
      snap_d = load ? D : snap_q;
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Blank mask follows the snapshot so it is stable for the whole frame.
   always_comb begin
      lit_d = load ? lit_mask(D) : lit_q;
      show  = lit_d[idx_d];
   end
`else
   assign show = 1'b1;
`endif

   // FSM outputs: nibble settles on slot entry, digit lit only while ON.
   always_comb begin
      a_d   = a_q;
      dig_d = {DIGITS{~DIG_ACTIVE}};
      fs_d  = load;
      if ((state_d == ST_DEAD) && (state_q != ST_DEAD)) begin
         a_d = snap_d[{idx_d, 2'b00} +: 4];
      end
      if ((state_d == ST_ON) && show) begin
         dig_d[idx_d] = DIG_ACTIVE;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         snap_q <= '0;
         a_q    <= 4'h0;
         dig_q  <= {DIGITS{~DIG_ACTIVE}};
         fs_q   <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         snap_q <= snap_d;
         a_q    <= a_d;
         dig_q  <= dig_d;
         fs_q   <= fs_d;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Blank mask register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lit_q <= '1;
      end else begin
         lit_q <= lit_d;
      end
   end
`endif

   assign A           = a_q;
   assign DIG_N       = dig_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with DIGITS=4, SCAN_DIV=8, DEAD_CYC=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_display_scan_mux;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        en    = 1'b0;
   logic [15:0] D     = 16'h0000;
   logic [3:0]  A;
   logic [3:0]  DIG_N;
   logic        frame_start;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   display_scan_mux #(
      .DIGITS   (4),
      .SCAN_DIV (8),
      .DEAD_CYC (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .D           (D),
      .A           (A),
      .DIG_N       (DIG_N),
      .frame_start (frame_start)
   );

   // Whether digit s of value v should light in this build.
   function automatic bit exp_lit(input logic [15:0] v, input int s);
`ifdef LEADING_ZERO_BLANK_EN
      logic [15:0] t;
      t = v >> (4 * s);
      return (s == 0) || (t != 16'h0);
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [3:0] nib(input logic [15:0] v, input int s);
      logic [15:0] t;
      t = v >> (4 * s);
      return t[3:0];
   endfunction

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (DIG_N !== 4'b1111) begin
         bad++;
         $display("FAIL reset_dign got=%b want=%b", DIG_N, 4'b1111);
      end
      total++;
      if (A !== 4'h0) begin
         bad++;
         $display("FAIL reset_a got=%h want=%h", A, 4'h0);
      end
      total++;
      if (frame_start !== 1'b0) begin
         bad++;
         $display("FAIL reset_fs got=%b want=%b", frame_start, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_scan();
      logic [3:0] ea;
      logic [3:0] ed;
      logic       ef;
      int         s;
      int         p;
      D  = 16'h1A3F;
      en = 1'b1;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         s  = c / 8;
         p  = c % 8;
         ea = nib(16'h1A3F, s);
         ed = 4'b1111;
         if (p >= 2 && exp_lit(16'h1A3F, s)) ed[s] = 1'b0;
         ef = (c == 0);
         total++;
         if (A !== ea) begin
            bad++;
            $display("FAIL scan_a c=%0d got=%h want=%h", c, A, ea);
         end
         total++;
         if (DIG_N !== ed) begin
            bad++;
            $display("FAIL scan_dign c=%0d got=%b want=%b", c, DIG_N, ed);
         end
         total++;
         if (frame_start !== ef) begin
            bad++;
            $display("FAIL scan_fs c=%0d got=%b want=%b", c, frame_start, ef);
         end
      end
   endtask

   task automatic test_snapshot();
      logic [15:0] v;
      logic [3:0]  ea;
      logic [3:0]  ed;
      logic        ef;
      int          s;
      int          p;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         v  = (c < 32) ? 16'h1A3F : 16'h0000;
         s  = (c % 32) / 8;
         p  = c % 8;
         ea = nib(v, s);
         ed = 4'b1111;
         if (p >= 2 && exp_lit(v, s)) ed[s] = 1'b0;
         ef = (c % 32 == 0);
         total++;
         if (A !== ea) begin
            bad++;
            $display("FAIL snap_a c=%0d got=%h want=%h", c, A, ea);
         end
         total++;
         if (DIG_N !== ed) begin
            bad++;
            $display("FAIL snap_dign c=%0d got=%b want=%b", c, DIG_N, ed);
         end
         total++;
         if (frame_start !== ef) begin
            bad++;
            $display("FAIL snap_fs c=%0d got=%b want=%b", c, frame_start, ef);
         end
         if (c == 10) D = 16'h0000;
      end
   endtask

   task automatic test_disable();
      en = 1'b0;
      @(negedge clk);
      total++;
      if (DIG_N !== 4'b1111) begin
         bad++;
         $display("FAIL off_dign got=%b want=%b", DIG_N, 4'b1111);
      end
      D  = 16'h3C07;
      en = 1'b1;
      @(negedge clk);
      total++;
      if (frame_start !== 1'b1) begin
         bad++;
         $display("FAIL restart_fs got=%b want=%b", frame_start, 1'b1);
      end
      total++;
      if (A !== 4'h7) begin
         bad++;
         $display("FAIL restart_a got=%h want=%h", A, 4'h7);
      end
      for (int c = 1; c <= 18; c++) @(negedge clk);
      total++;
      if (DIG_N !== 4'b1011 || A !== 4'hC) begin
         bad++;
         $display("FAIL slot2_on got=%b/%h want=%b/%h", DIG_N, A, 4'b1011, 4'hC);
      end
      en = 1'b0;
      @(negedge clk);
      total++;
      if (DIG_N !== 4'b1111) begin
         bad++;
         $display("FAIL dis_dign got=%b want=%b", DIG_N, 4'b1111);
      end
      D  = 16'h5E42;
      en = 1'b1;
      @(negedge clk);
      total++;
      if (frame_start !== 1'b1 || A !== 4'h2 || DIG_N !== 4'b1111) begin
         bad++;
         $display("FAIL reen got=%b/%h/%b want=1/2/1111", frame_start, A, DIG_N);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (DIG_N !== 4'b1110) begin
         bad++;
         $display("FAIL reen_on got=%b want=%b", DIG_N, 4'b1110);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ea;
      logic [3:0] ed;
      logic       ef;
      int         s;
      int         p;
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      total++;
      if (DIG_N !== 4'b1111 || frame_start !== 1'b0) begin
         bad++;
         $display("FAIL toggle_off got=%b/%b want=1111/0", DIG_N, frame_start);
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         s  = (c % 32) / 8;
         p  = c % 8;
         ea = nib(16'h5E42, s);
         ed = 4'b1111;
         if (p >= 2 && exp_lit(16'h5E42, s)) ed[s] = 1'b0;
         ef = (c % 32 == 0);
         total++;
         if (A !== ea || DIG_N !== ed || frame_start !== ef) begin
            bad++;
            $display("FAIL b2b c=%0d got=%h/%b/%b want=%h/%b/%b",
                     c, A, DIG_N, frame_start, ea, ed, ef);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 40; c <= 58; c++) @(negedge clk);
      total++;
      if (DIG_N !== 4'b0111 || A !== 4'h5) begin
         bad++;
         $display("FAIL slot3_on got=%b/%h want=%b/%h", DIG_N, A, 4'b0111, 4'h5);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (DIG_N !== 4'b1111 || A !== 4'h0 || frame_start !== 1'b0) begin
         bad++;
         $display("FAIL midrst got=%b/%h/%b want=1111/0/0", DIG_N, A, frame_start);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (frame_start !== 1'b1 || A !== 4'h2 || DIG_N !== 4'b1111) begin
         bad++;
         $display("FAIL rst_restart got=%b/%h/%b want=1/2/1111", frame_start, A, DIG_N);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (DIG_N !== 4'b1110) begin
         bad++;
         $display("FAIL rst_restart_on got=%b want=%b", DIG_N, 4'b1110);
      end
   endtask

   task automatic test_blank();
      logic [15:0] v;
      logic [3:0]  ea;
      logic [3:0]  ed;
      int          s;
      int          p;
      en = 1'b0;
      @(negedge clk);
      D  = 16'h0050;
      en = 1'b1;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         v  = (c < 32) ? 16'h0050 : 16'h0000;
         s  = (c % 32) / 8;
         p  = c % 8;
         ea = nib(v, s);
         ed = 4'b1111;
         if (p >= 2 && exp_lit(v, s)) ed[s] = 1'b0;
         total++;
         if (A !== ea) begin
            bad++;
            $display("FAIL blank_a c=%0d got=%h want=%h", c, A, ea);
         end
         total++;
         if (DIG_N !== ed) begin
            bad++;
            $display("FAIL blank_dign c=%0d got=%b want=%b", c, DIG_N, ed);
         end
         if (c == 20) D = 16'h0000;
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_snapshot();
      test_disable();
      test_back_to_back();
      test_reset_mid();
      test_blank();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
